// File: rtl/assert_log_pkg.sv
// Shared types and default widths for the assertion failure logger.
package assert_log_pkg;

    localparam int unsigned ALOG_NUM_CHK_DEF   = 2;
    localparam int unsigned ALOG_TS_W_DEF      = 16;
    localparam int unsigned ALOG_CNT_W_DEF     = 16;
    localparam int unsigned ALOG_DEPTH_DEF     = 8;
    localparam int unsigned ALOG_MAX_FAILS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FAILED = 2'd2,
        HALTED = 2'd3
    } alog_state_e;

    // One failure record: timestamp of the failing sample and the sampled bits.
    typedef struct packed {
        logic [ALOG_TS_W_DEF-1:0]    ts;
        logic [ALOG_NUM_CHK_DEF-1:0] sig;
    } alog_rec_t;

    localparam int unsigned ALOG_REC_W = $bits(alog_rec_t);

endpackage

// File: rtl/alog_fifo.sv
// First-word fall-through FIFO holding failure records; dout reads 0 while empty.
module alog_fifo
    import assert_log_pkg::*;
#(
    parameter int unsigned DEPTH = ALOG_DEPTH_DEF,
    parameter int unsigned W     = ALOG_REC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push_c;
    logic          do_pop_c;

    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign dout      = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (do_push_c && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/assert_fail_logger.sv
// Counts pass/fail samples of an all-ones check and logs timestamped failures.
// Optional macro ALOG_HALT_EN: stop sampling once fail_cnt reaches MAX_FAILS.
module assert_fail_logger
    import assert_log_pkg::*;
#(
    parameter int unsigned NUM_CHK   = ALOG_NUM_CHK_DEF,
    parameter int unsigned TS_W      = ALOG_TS_W_DEF,
    parameter int unsigned CNT_W     = ALOG_CNT_W_DEF,
    parameter int unsigned DEPTH     = ALOG_DEPTH_DEF,
    parameter int unsigned MAX_FAILS = ALOG_MAX_FAILS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               chk_en,
    input  logic [NUM_CHK-1:0] sig,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [TS_W-1:0]    rec_ts,
    output logic [NUM_CHK-1:0] rec_sig,
    output logic               overflow,
    output logic               any_fail,
    output logic [1:0]         state
);

    localparam int unsigned REC_W = TS_W + NUM_CHK;
    localparam int unsigned CW1   = CNT_W + 1;
`ifdef ALOG_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    alog_state_e      state_q;
    alog_state_e      state_d;
    logic [TS_W-1:0]  ts_q;
    logic [REC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             sample_c;
    logic             pass_c;
    logic             fail_c;
    logic             pop_c;
    logic             halt_hit_c;

    // Sample qualification: clr drops the sample, HALTED ignores chk_en.
    assign sample_c   = chk_en && !clr && (state_q != HALTED);
    assign pass_c     = sample_c && (&sig);
    assign fail_c     = sample_c && !(&sig);
    assign pop_c      = rec_ready && !fifo_empty && !clr;
    assign halt_hit_c = HALT_EN && fail_c &&
                        (({1'b0, fail_cnt} + CW1'(1)) >= CW1'(MAX_FAILS));

    assign rec_valid = !fifo_empty;
    assign rec_ts    = head[REC_W-1:NUM_CHK];
    assign rec_sig   = head[NUM_CHK-1:0];
    assign state     = state_q;

    // Timestamp, saturating counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
            any_fail <= 1'b0;
        end else if (clr) begin
            ts_q     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            overflow <= 1'b0;
            any_fail <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (pass_c && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
            if (fail_c && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
            if (fail_c) any_fail <= 1'b1;
            if (fail_c && fifo_full && !pop_c) overflow <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a failing first sample goes straight to FAILED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (sample_c) state_d = fail_c ? FAILED : ARMED;
            ARMED:  if (fail_c)   state_d = FAILED;
            FAILED: state_d = FAILED;
            HALTED: state_d = HALTED;
        endcase
        if (halt_hit_c) state_d = HALTED;
        if (clr)        state_d = IDLE;
    end

    // Failure record queue.
    alog_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (fail_c),
        .pop   (pop_c),
        .din   ({ts_q, sig}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_assert_fail_logger.sv
// Directed bench for assert_fail_logger with a record scoreboard.
module tb_assert_fail_logger;

`ifdef ALOG_HALT_EN
    localparam int NREC6  = 4;
    localparam int FAIL6  = 4;
    localparam int STATE6 = 3;
`else
    localparam int NREC6  = 6;
    localparam int FAIL6  = 6;
    localparam int STATE6 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        chk_en = 1'b0;
    logic [1:0]  sig = 2'b11;
    logic        rec_ready = 1'b0;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        rec_valid;
    logic [15:0] rec_ts;
    logic [1:0]  rec_sig;
    logic        overflow;
    logic        any_fail;
    logic [1:0]  state;

    int n_chk = 0;
    int n_fail = 0;
    logic [17:0] exp_q[$];

    assert_fail_logger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .chk_en    (chk_en),
        .sig       (sig),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_ts    (rec_ts),
        .rec_sig   (rec_sig),
        .overflow  (overflow),
        .any_fail  (any_fail),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ts, input logic [1:0] s);
        exp_q.push_back({16'(ts), s});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        check({p, "_pass"},     int'(pass_cnt),  0);
        check({p, "_fail"},     int'(fail_cnt),  0);
        check({p, "_valid"},    int'(rec_valid), 0);
        check({p, "_ts"},       int'(rec_ts),    0);
        check({p, "_sig"},      int'(rec_sig),   0);
        check({p, "_overflow"}, int'(overflow),  0);
        check({p, "_any_fail"}, int'(any_fail),  0);
        check({p, "_state"},    int'(state),     0);
    endtask

    task automatic do_reset(input string p);
        rst_n = 1'b0;
        clr = 1'b0;
        chk_en = 1'b0;
        sig = 2'b11;
        rec_ready = 1'b0;
        exp_q.delete();
        #2;
        check_zero(p);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string p);
        rec_ready = 1'b1;
        for (int i = 0; i < 20 && rec_valid; i++) step();
        rec_ready = 1'b0;
        check({p, "_drained"}, int'(rec_valid), 0);
        check({p, "_left"}, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every accepted record must match the queue head.
    always @(negedge clk) begin
        if (rst_n && !clr && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rec_unexpected: got ts=%0d sig=%b expected no record", rec_ts, rec_sig);
            end else begin
                check("rec_head", int'({rec_ts, rec_sig}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [1:0] v2 [6];
        logic [1:0] v6 [6];
        v2 = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01};
        v6 = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

        #1;
        // 1: five passing samples
        do_reset("t1_rst");
        chk_en = 1'b1;
        sig = 2'b11;
        repeat (5) step();
        chk_en = 1'b0;
        check("t1_pass",  int'(pass_cnt),  5);
        check("t1_fail",  int'(fail_cnt),  0);
        check("t1_state", int'(state),     1);
        check("t1_valid", int'(rec_valid), 0);

        // 2: mixed pattern, records (2,10) (4,01) (5,01)
        do_reset("t2_rst");
        push_exp(2, 2'b10);
        push_exp(4, 2'b01);
        push_exp(5, 2'b01);
        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sig = v2[i];
            step();
        end
        chk_en = 1'b0;
        check("t2_fail",     int'(fail_cnt),  3);
        check("t2_pass",     int'(pass_cnt),  3);
        check("t2_state",    int'(state),     2);
        check("t2_any_fail", int'(any_fail),  1);
        check("t2_valid",    int'(rec_valid), 1);
        check("t2_overflow", int'(overflow),  0);
        drain("t2");

`ifndef ALOG_HALT_EN
        // 3: ten fails into an 8-deep FIFO, then reset in the middle of draining
        do_reset("t3_rst");
        chk_en = 1'b1;
        sig = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) push_exp(i, 2'b00);
            step();
        end
        chk_en = 1'b0;
        check("t3_fail",     int'(fail_cnt),  10);
        check("t3_overflow", int'(overflow),  1);
        check("t3_valid",    int'(rec_valid), 1);
        check("t3_head_ts",  int'(rec_ts),    0);
        rec_ready = 1'b1;
        repeat (3) step();
        check("t3_mid_ts", int'(rec_ts), 3);
        rst_n = 1'b0;
        #1;
        check_zero("t3_async");
        exp_q.delete();
        rec_ready = 1'b0;

        // 4: push into a full FIFO while popping keeps the record
        do_reset("t4_rst");
        chk_en = 1'b1;
        sig = 2'b00;
        for (int i = 0; i < 8; i++) begin
            push_exp(i, 2'b00);
            step();
        end
        push_exp(8, 2'b00);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        chk_en = 1'b0;
        check("t4_overflow", int'(overflow),  0);
        check("t4_fail",     int'(fail_cnt),  9);
        check("t4_valid",    int'(rec_valid), 1);
        drain("t4");
`endif

        // 5: clr beats a failing sample and zeroes everything including ts
        do_reset("t5_rst");
        chk_en = 1'b1;
        sig = 2'b00;
        step();
        check("t5_pre_any_fail", int'(any_fail), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_en = 1'b0;
        check("t5_fail",     int'(fail_cnt),  0);
        check("t5_pass",     int'(pass_cnt),  0);
        check("t5_any_fail", int'(any_fail),  0);
        check("t5_state",    int'(state),     0);
        check("t5_valid",    int'(rec_valid), 0);
        check("t5_overflow", int'(overflow),  0);
        push_exp(0, 2'b10);
        chk_en = 1'b1;
        sig = 2'b10;
        step();
        chk_en = 1'b0;
        check("t5_fail_after", int'(fail_cnt), 1);
        drain("t5");

        // 6: six fails, halt behaviour depends on build
        do_reset("t6_rst");
        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sig = v6[i];
            if (i < NREC6) push_exp(i, v6[i]);
            step();
        end
        chk_en = 1'b0;
        check("t6_fail",  int'(fail_cnt), FAIL6);
        check("t6_state", int'(state),    STATE6);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
